// File: rtl/disp_pkg.sv
// Shared definitions for the display scan driver: code field layout,
// segment glyph constants and the blink phase type.
package disp_pkg;

    localparam int CODE_W     = 6;
    localparam int NUM_DIGITS = 8;

    localparam int DASH_BIT = 5;
    localparam int SYM_BIT  = 0;
    localparam int IDX_LSB  = 1;
    localparam int IDX_MSB  = 4;

    localparam logic [CODE_W-1:0] CODE_DASH = 6'b111111;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] AN_OFF   = 8'hFF;
    localparam logic [7:0] SEG_DASH = 8'hBF;

    // Hex glyphs, {dp,g,f,e,d,c,b,a} active-low
    localparam logic [7:0] HEX_0 = 8'hC0;
    localparam logic [7:0] HEX_1 = 8'hF9;
    localparam logic [7:0] HEX_2 = 8'hA4;
    localparam logic [7:0] HEX_3 = 8'hB0;
    localparam logic [7:0] HEX_4 = 8'h99;
    localparam logic [7:0] HEX_5 = 8'h92;
    localparam logic [7:0] HEX_6 = 8'h82;
    localparam logic [7:0] HEX_7 = 8'hF8;
    localparam logic [7:0] HEX_8 = 8'h80;
    localparam logic [7:0] HEX_9 = 8'h90;
    localparam logic [7:0] HEX_A = 8'h88;
    localparam logic [7:0] HEX_B = 8'h83;
    localparam logic [7:0] HEX_C = 8'hC6;
    localparam logic [7:0] HEX_D = 8'hA1;
    localparam logic [7:0] HEX_E = 8'h86;
    localparam logic [7:0] HEX_F = 8'h8E;

    // Symbol glyphs
    localparam logic [7:0] SYM_1 = 8'hF9;
    localparam logic [7:0] SYM_2 = 8'hA4;
    localparam logic [7:0] SYM_G = 8'h82;
    localparam logic [7:0] SYM_P = 8'h8C;
    localparam logic [7:0] SYM_B = 8'h83;
    localparam logic [7:0] SYM_C = 8'hA7;
    localparam logic [7:0] SYM_S = 8'h92;
    localparam logic [7:0] SYM_E = 8'h86;
    localparam logic [7:0] SYM_U = 8'hC1;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_DARK    = 1'b1
    } blink_phase_e;

    function automatic logic [3:0] code_index(input logic [CODE_W-1:0] code);
        return code[IDX_MSB:IDX_LSB];
    endfunction

endpackage

// File: rtl/disp_glyph_dec.sv
// Combinational display-code to 7-segment glyph decoder.
module disp_glyph_dec
    import disp_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [7:0]        seg_o
);

    logic [3:0] idx;

    assign idx = code_index(code_i);

    always_comb begin
        seg_o = SEG_OFF;
        if (code_i[DASH_BIT]) begin
            seg_o = SEG_DASH;
        end else if (!code_i[SYM_BIT]) begin
            case (idx)
                4'h0:    seg_o = HEX_0;
                4'h1:    seg_o = HEX_1;
                4'h2:    seg_o = HEX_2;
                4'h3:    seg_o = HEX_3;
                4'h4:    seg_o = HEX_4;
                4'h5:    seg_o = HEX_5;
                4'h6:    seg_o = HEX_6;
                4'h7:    seg_o = HEX_7;
                4'h8:    seg_o = HEX_8;
                4'h9:    seg_o = HEX_9;
                4'hA:    seg_o = HEX_A;
                4'hB:    seg_o = HEX_B;
                4'hC:    seg_o = HEX_C;
                4'hD:    seg_o = HEX_D;
                4'hE:    seg_o = HEX_E;
                default: seg_o = HEX_F;
            endcase
        end else begin
            // Unused symbol indices fall through to a blank digit.
            case (idx)
                4'd1:    seg_o = SYM_1;
                4'd2:    seg_o = SYM_2;
                4'd6:    seg_o = SYM_G;
                4'd10:   seg_o = SYM_P;
                4'd11:   seg_o = SYM_B;
                4'd12:   seg_o = SYM_C;
                4'd13:   seg_o = SYM_S;
                4'd14:   seg_o = SYM_E;
                4'd15:   seg_o = SYM_U;
                default: seg_o = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/disp_scan_drv.sv
// Eight-digit common-anode scan driver with frame snapshots, ghost blanking
// and whole-display blink.
//   state      | meaning
//   PH_VISIBLE | digits driven normally
//   PH_DARK    | all anodes off for whole frames (blink off half)
module disp_scan_drv
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYC    = 2000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CODE_W-1:0] d1,
    input  logic [CODE_W-1:0] d2,
    input  logic [CODE_W-1:0] d3,
    input  logic [CODE_W-1:0] d4,
    input  logic [CODE_W-1:0] d5,
    input  logic [CODE_W-1:0] d6,
    input  logic [CODE_W-1:0] d7,
    input  logic [CODE_W-1:0] d8,
    input  logic              blink,
    output logic [7:0]        an,
    output logic [7:0]        seg,
    output logic              frame_tick
);

    localparam int SLOT_W  = $clog2(REFRESH_DIV);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]  SLOT_BLANK = SLOT_W'(BLANK_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [2:0]         idx_q, idx_d;
    logic               init_q;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;
    blink_phase_e       phase_q, phase_d;
    logic [7:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;
    logic               tick_q;
    logic               snap;

    logic [CODE_W-1:0]  d_in     [NUM_DIGITS];
    logic [CODE_W-1:0]  shadow_q [NUM_DIGITS];
    logic [CODE_W-1:0]  cur_code;
    logic [7:0]         cur_glyph;

    assign d_in = '{d1, d2, d3, d4, d5, d6, d7, d8};

    // The first cycle after reset only takes the snapshot; counting starts
    // afterwards so the first frame is scanned from fresh shadow data.
    assign snap = init_q || (slot_q == SLOT_LAST && idx_q == 3'd7);

    assign cur_code = shadow_q[idx_q];

    disp_glyph_dec u_dec (
        .code_i (cur_code),
        .seg_o  (cur_glyph)
    );

    always_comb begin
        slot_d = slot_q;
        idx_d  = idx_q;
        if (!init_q) begin
            if (slot_q == SLOT_LAST) begin
                slot_d = '0;
                idx_d  = idx_q + 3'd1;
            end else begin
                slot_d = slot_q + SLOT_W'(1);
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        if (!blink) begin
            phase_d = PH_VISIBLE;
            bcnt_d  = '0;
        end else if (snap) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = (phase_q == PH_VISIBLE) ? PH_DARK : PH_VISIBLE;
            end else begin
                bcnt_d = bcnt_q + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        if (!init_q && phase_q == PH_VISIBLE && slot_q >= SLOT_BLANK) begin
            an_d  = ~(8'h01 << idx_q);
            seg_d = cur_glyph;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q  <= '0;
            idx_q   <= '0;
            init_q  <= 1'b1;
            bcnt_q  <= '0;
            phase_q <= PH_VISIBLE;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            tick_q  <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            init_q  <= 1'b0;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= snap;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= CODE_DASH;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= d_in[i];
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_drv.sv
// Directed bench for disp_scan_drv with a 4-cycle slot, 1 blank cycle and
// 2-frame blink half-period.
module tb_disp_scan_drv;

    logic       clock;
    logic       reset;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic       blink;
    logic [7:0] an;
    logic [7:0] seg;
    logic       frame_tick;

    int checks;
    int errors;

    logic [7:0] an_cap  [31];
    logic [7:0] seg_cap [31];
    logic       ft_cap  [31];

    disp_scan_drv #(
        .REFRESH_DIV  (4),
        .BLANK_CYC    (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .d1         (d1),
        .d2         (d2),
        .d3         (d3),
        .d4         (d4),
        .d5         (d5),
        .d6         (d6),
        .d7         (d7),
        .d8         (d8),
        .blink      (blink),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Anode exclusivity on every cycle
    always @(negedge clock) begin
        checks++;
        if ($countones(~an) > 1) begin
            errors++;
            $display("FAIL onehot an got %h exp at most one low bit", an);
        end
    end

    // Sample index i corresponds to slot i/4, slot cycle i%4 after a tick.
    task automatic capture();
        for (int i = 0; i < 31; i++) begin
            @(negedge clock);
            an_cap[i]  = an;
            seg_cap[i] = seg;
            ft_cap[i]  = frame_tick;
        end
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (frame_tick === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tick_timeout got no frame_tick exp one within 200 cycles");
        end
    endtask

    task automatic test_reset();
        logic [7:0] ea, es;
        reset = 1'b0;
        blink = 1'b0;
        d1 = 6'b011111;
        {d2, d3, d4, d5, d6, d7, d8} = {7{6'b111111}};
        repeat (3) @(negedge clock);
        checks++;
        if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got %h exp ff", an); end
        checks++;
        if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h exp ff", seg); end
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL first_tick got %b exp 1", frame_tick); end
        capture();
        for (int i = 0; i < 31; i++) begin
            ea = (i % 4 == 0) ? 8'hFF : ~(8'h01 << (i / 4));
            es = (i % 4 == 0) ? 8'hFF : ((i / 4 == 0) ? 8'hC1 : 8'hBF);
            checks++;
            if (an_cap[i] !== ea) begin errors++; $display("FAIL frame0_an[%0d] got %h exp %h", i, an_cap[i], ea); end
            checks++;
            if (seg_cap[i] !== es) begin errors++; $display("FAIL frame0_seg[%0d] got %h exp %h", i, seg_cap[i], es); end
            checks++;
            if (ft_cap[i] !== 1'b0) begin errors++; $display("FAIL single_tick[%0d] got %b exp 0", i, ft_cap[i]); end
        end
    endtask

    task automatic test_glyphs();
        logic [7:0] es [8];
        es = '{8'hA7, 8'hA4, 8'hBF, 8'h83, 8'h92, 8'hBF, 8'hBF, 8'hBF};
        d5 = 6'b001010;
        d4 = 6'b010111;
        d2 = 6'b000100;
        d1 = 6'b011001;
        wait_tick();
        capture();
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (an_cap[4*s+1] !== ~(8'h01 << s)) begin
                errors++; $display("FAIL glyph_an[%0d] got %h exp %h", s, an_cap[4*s+1], ~(8'h01 << s));
            end
            checks++;
            if (seg_cap[4*s+2] !== es[s]) begin
                errors++; $display("FAIL glyph_seg[%0d] got %h exp %h", s, seg_cap[4*s+2], es[s]);
            end
        end
    endtask

    task automatic test_freeze();
        d1 = 6'b011111;
        d8 = 6'b111111;
        wait_tick();
        for (int i = 0; i < 31; i++) begin
            @(negedge clock);
            an_cap[i]  = an;
            seg_cap[i] = seg;
            if (i == 13) begin
                d1 = 6'b010101;
                d8 = 6'b000000;
            end
        end
        checks++;
        if (seg_cap[1] !== 8'hC1) begin errors++; $display("FAIL freeze_d1_old got %h exp c1", seg_cap[1]); end
        checks++;
        if (an_cap[29] !== 8'h7F) begin errors++; $display("FAIL freeze_an7 got %h exp 7f", an_cap[29]); end
        checks++;
        if (seg_cap[30] !== 8'hBF) begin errors++; $display("FAIL freeze_d8_old got %h exp bf", seg_cap[30]); end
        wait_tick();
        capture();
        checks++;
        if (an_cap[1] !== 8'hFE) begin errors++; $display("FAIL freeze_an0_new got %h exp fe", an_cap[1]); end
        checks++;
        if (seg_cap[1] !== 8'h8C) begin errors++; $display("FAIL freeze_d1_new got %h exp 8c", seg_cap[1]); end
        checks++;
        if (seg_cap[29] !== 8'hC0) begin errors++; $display("FAIL freeze_d8_new got %h exp c0", seg_cap[29]); end
    endtask

    task automatic test_blank_codes();
        d1 = 6'b000001;
        d2 = 6'b010001;
        d3 = 6'b100000;
        wait_tick();
        capture();
        checks++;
        if (an_cap[0] !== 8'hFF) begin errors++; $display("FAIL ghost_blank got %h exp ff", an_cap[0]); end
        checks++;
        if (an_cap[1] !== 8'hFE) begin errors++; $display("FAIL sym0_an got %h exp fe", an_cap[1]); end
        checks++;
        if (seg_cap[1] !== 8'hFF) begin errors++; $display("FAIL sym0_seg got %h exp ff", seg_cap[1]); end
        checks++;
        if (an_cap[5] !== 8'hFD) begin errors++; $display("FAIL sym8_an got %h exp fd", an_cap[5]); end
        checks++;
        if (seg_cap[5] !== 8'hFF) begin errors++; $display("FAIL sym8_seg got %h exp ff", seg_cap[5]); end
        checks++;
        if (seg_cap[9] !== 8'hBF) begin errors++; $display("FAIL dash_bit_seg got %h exp bf", seg_cap[9]); end
    endtask

    task automatic test_blink();
        wait_tick();
        blink = 1'b1;
        capture();
        checks++;
        if (an_cap[1] !== 8'hFE) begin errors++; $display("FAIL blink_f0 got %h exp fe", an_cap[1]); end
        checks++;
        if (an_cap[13] !== 8'hF7) begin errors++; $display("FAIL blink_f0_s3 got %h exp f7", an_cap[13]); end
        wait_tick();
        capture();
        checks++;
        if (an_cap[1] !== 8'hFE) begin errors++; $display("FAIL blink_f1 got %h exp fe", an_cap[1]); end
        wait_tick();
        capture();
        checks++;
        if (an_cap[1] !== 8'hFF) begin errors++; $display("FAIL blink_f2 got %h exp ff", an_cap[1]); end
        checks++;
        if (an_cap[25] !== 8'hFF) begin errors++; $display("FAIL blink_f2_s6 got %h exp ff", an_cap[25]); end
        wait_tick();
        for (int i = 0; i < 31; i++) begin
            @(negedge clock);
            an_cap[i] = an;
            if (i == 2) blink = 1'b0;
        end
        checks++;
        if (an_cap[1] !== 8'hFF) begin errors++; $display("FAIL blink_f3 got %h exp ff", an_cap[1]); end
        checks++;
        if (an_cap[3] !== 8'hFF) begin errors++; $display("FAIL blink_drop_lag got %h exp ff", an_cap[3]); end
        checks++;
        if (an_cap[5] !== 8'hFD) begin errors++; $display("FAIL blink_drop_resume got %h exp fd", an_cap[5]); end
        // Rise on the cycle of the tick edge: that tick is counted.
        blink = 1'b1;
        wait_tick();
        capture();
        checks++;
        if (an_cap[1] !== 8'hFE) begin errors++; $display("FAIL blink_sim_g0 got %h exp fe", an_cap[1]); end
        wait_tick();
        capture();
        checks++;
        if (an_cap[1] !== 8'hFF) begin errors++; $display("FAIL blink_sim_g1 got %h exp ff", an_cap[1]); end
        blink = 1'b0;
    endtask

    task automatic test_reset_mid();
        d1 = 6'b011111;
        wait_tick();
        repeat (22) @(negedge clock);
        checks++;
        if (an !== 8'hDF) begin errors++; $display("FAIL pre_reset_an got %h exp df", an); end
        reset = 1'b0;
        #1;
        checks++;
        if (an !== 8'hFF) begin errors++; $display("FAIL async_an got %h exp ff", an); end
        checks++;
        if (seg !== 8'hFF) begin errors++; $display("FAIL async_seg got %h exp ff", seg); end
        d2 = 6'b000110;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL restart_tick got %b exp 1", frame_tick); end
        capture();
        checks++;
        if (an_cap[0] !== 8'hFF) begin errors++; $display("FAIL restart_blank got %h exp ff", an_cap[0]); end
        checks++;
        if (an_cap[1] !== 8'hFE) begin errors++; $display("FAIL restart_an got %h exp fe", an_cap[1]); end
        checks++;
        if (seg_cap[1] !== 8'hC1) begin errors++; $display("FAIL restart_seg0 got %h exp c1", seg_cap[1]); end
        checks++;
        if (seg_cap[5] !== 8'hB0) begin errors++; $display("FAIL restart_snap_d2 got %h exp b0", seg_cap[5]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_glyphs();
        test_freeze();
        test_blank_codes();
        test_blink();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
